// File: rtl/procyon_ccu_mhq_entry_mb.sv
// procyon_ccu_mhq_entry_mb: one MHQ slot that fills its line over several CCU beats and
// merges store bytes. Optional macro PCYN_MHQ_CRIT_BEAT_FIRST_EN: fill critical beat first.

module procyon_ccu_mhq_byte (
   input  logic       clk,
   input  logic       rst,
   input  logic       alloc,
   input  logic       store_wr,
   input  logic       beat_wr,
   input  logic [7:0] store_byte,
   input  logic [7:0] beat_byte,
   output logic [7:0] data
);
   logic updated;

   // Store data always beats fill data, including a store landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= '0;
         updated <= 1'b0;
      end else begin
         if (alloc)         updated <= 1'b0;
         else if (store_wr) updated <= 1'b1;
         if (store_wr)                 data <= store_byte;
         else if (beat_wr && !updated) data <= beat_byte;
      end
   end
endmodule

module procyon_ccu_mhq_entry_mb #(
   parameter  int OPTN_ADDR_WIDTH    = 32,
   parameter  int OPTN_DC_LINE_SIZE  = 32,
   parameter  int OPTN_CCU_BEAT_SIZE = 8,
   localparam int DC_OFFSET   = $clog2(OPTN_DC_LINE_SIZE),
   localparam int BEAT_OFFSET = $clog2(OPTN_CCU_BEAT_SIZE),
   localparam int NUM_BEATS   = OPTN_DC_LINE_SIZE / OPTN_CCU_BEAT_SIZE,
   localparam int BEAT_IDX_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
   localparam int LINE_W      = OPTN_DC_LINE_SIZE * 8,
   localparam int BEAT_W      = OPTN_CCU_BEAT_SIZE * 8,
   localparam int TAG_W       = OPTN_ADDR_WIDTH - DC_OFFSET
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         o_mhq_entry_valid,
   output logic                         o_mhq_entry_complete,
   output logic                         o_mhq_entry_dirty,
   output logic [TAG_W-1:0]             o_mhq_entry_addr,
   output logic [LINE_W-1:0]            o_mhq_entry_data,
   output logic [BEAT_IDX_W-1:0]        o_ccu_next_beat,
   input  logic [OPTN_ADDR_WIDTH-1:0]   i_lookup_addr,
   output logic                         o_lookup_hit,
   output logic                         o_lookup_beat_avail,
   input  logic                         i_update_en,
   input  logic                         i_update_we,
   input  logic [LINE_W-1:0]            i_update_wr_data,
   input  logic [OPTN_DC_LINE_SIZE-1:0] i_update_byte_select,
   input  logic [OPTN_ADDR_WIDTH-1:0]   i_update_addr,
   input  logic                         i_ccu_beat_valid,
   input  logic [BEAT_W-1:0]            i_ccu_beat_data,
   input  logic                         i_fill_launched
);
   typedef enum logic [1:0] {ST_INVALID, ST_FILLING, ST_COMPLETE} state_t;

   state_t                state, state_next;
   logic                  dirty;
   logic [TAG_W-1:0]      addr;
   logic [NUM_BEATS-1:0]  beat_arrived;
   logic [BEAT_IDX_W-1:0] beat_cnt, beat_cnt_inc, crit_beat, lookup_beat;
   logic [BEAT_IDX_W:0]   beats_left;
   logic                  alloc, store_wr, beat_accept, last_beat, lookup_arrived;
   logic                  unused_addr_bits;

   assign alloc       = (state == ST_INVALID) && i_update_en;
   assign store_wr    = (state != ST_INVALID) && i_update_en && i_update_we;
   assign beat_accept = (state == ST_FILLING) && i_ccu_beat_valid;
   assign last_beat   = beat_accept && (beats_left == (BEAT_IDX_W+1)'(1));

   assign beat_cnt_inc = (NUM_BEATS > 1) ? beat_cnt + BEAT_IDX_W'(1) : '0;
   assign unused_addr_bits = ^{i_lookup_addr[DC_OFFSET-1:0], i_update_addr[DC_OFFSET-1:0]};

   if (NUM_BEATS > 1) begin : g_multi_beat
      assign lookup_beat = i_lookup_addr[DC_OFFSET-1:BEAT_OFFSET];
`ifdef PCYN_MHQ_CRIT_BEAT_FIRST_EN
      assign crit_beat = i_update_addr[DC_OFFSET-1:BEAT_OFFSET];
`else
      assign crit_beat = '0;
`endif
   end else begin : g_single_beat
      assign lookup_beat = '0;
      assign crit_beat   = '0;
   end

   // A store in COMPLETE holds off the launch so the merged data is not lost.
   always_comb begin
      state_next = state;
      case (state)
         ST_INVALID:  if (i_update_en) state_next = ST_FILLING;
         ST_FILLING:  if (last_beat) state_next = ST_COMPLETE;
         ST_COMPLETE: if (i_fill_launched && !store_wr) state_next = ST_INVALID;
         default:     state_next = ST_INVALID;
      endcase
   end

   always_comb begin
      lookup_arrived = 1'b0;
      for (int b = 0; b < NUM_BEATS; b++)
         if (lookup_beat == BEAT_IDX_W'(b)) lookup_arrived = beat_arrived[b];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_INVALID;
         dirty        <= 1'b0;
         addr         <= '0;
         beat_arrived <= '0;
         beat_cnt     <= '0;
         beats_left   <= '0;
      end else begin
         state <= state_next;
         if (alloc) begin
            addr         <= i_update_addr[OPTN_ADDR_WIDTH-1:DC_OFFSET];
            dirty        <= i_update_we;
            beat_arrived <= '0;
            beat_cnt     <= crit_beat;
            beats_left   <= (BEAT_IDX_W+1)'(NUM_BEATS);
         end else begin
            if (store_wr) dirty <= 1'b1;
            if (beat_accept) begin
               for (int b = 0; b < NUM_BEATS; b++)
                  if (beat_cnt == BEAT_IDX_W'(b)) beat_arrived[b] <= 1'b1;
               beat_cnt   <= beat_cnt_inc;
               beats_left <= beats_left - (BEAT_IDX_W+1)'(1);
            end
         end
      end
   end

   for (genvar i = 0; i < OPTN_DC_LINE_SIZE; i++) begin : g_byte
      procyon_ccu_mhq_byte u_byte (
         .clk        (clk),
         .rst        (rst),
         .alloc      (alloc),
         .store_wr   (store_wr && i_update_byte_select[i]),
         .beat_wr    (beat_accept && (beat_cnt == BEAT_IDX_W'(i / OPTN_CCU_BEAT_SIZE))),
         .store_byte (i_update_wr_data[i*8 +: 8]),
         .beat_byte  (i_ccu_beat_data[(i % OPTN_CCU_BEAT_SIZE)*8 +: 8]),
         .data       (o_mhq_entry_data[i*8 +: 8])
      );
   end

   assign o_mhq_entry_valid    = (state != ST_INVALID);
   assign o_mhq_entry_complete = (state == ST_COMPLETE) && !(i_update_en && i_update_we);
   assign o_mhq_entry_dirty    = dirty;
   assign o_mhq_entry_addr     = addr;
   assign o_ccu_next_beat      = beat_cnt;
   assign o_lookup_hit         = o_mhq_entry_valid && (i_lookup_addr[OPTN_ADDR_WIDTH-1:DC_OFFSET] == addr);
   assign o_lookup_beat_avail  = o_lookup_hit && lookup_arrived;
endmodule

// File: tb/tb_procyon_ccu_mhq_entry_mb.sv
// Scoreboard bench for procyon_ccu_mhq_entry_mb: 4-beat instance against a line-level model,
// plus a directed 1-beat instance.
module tb_procyon_ccu_mhq_entry_mb;
   localparam int LINE = 32, BEAT = 8, NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-beat instance
   logic         rst, en, we, bv, launch;
   logic [255:0] wdata;
   logic [31:0]  sel, uaddr, laddr;
   logic [63:0]  bdata;
   logic         valid, complete, dirty, hit, avail;
   logic [26:0]  addr_o;
   logic [255:0] data_o;
   logic [1:0]   next_o;

   procyon_ccu_mhq_entry_mb u_dut (
      .clk(clk), .rst(rst),
      .o_mhq_entry_valid(valid), .o_mhq_entry_complete(complete), .o_mhq_entry_dirty(dirty),
      .o_mhq_entry_addr(addr_o), .o_mhq_entry_data(data_o), .o_ccu_next_beat(next_o),
      .i_lookup_addr(laddr), .o_lookup_hit(hit), .o_lookup_beat_avail(avail),
      .i_update_en(en), .i_update_we(we), .i_update_wr_data(wdata),
      .i_update_byte_select(sel), .i_update_addr(uaddr),
      .i_ccu_beat_valid(bv), .i_ccu_beat_data(bdata), .i_fill_launched(launch)
   );

   // single-beat instance
   logic         rst1, en1, we1, bv1, launch1;
   logic [255:0] wdata1, bdata1, data1, pay1;
   logic [31:0]  sel1, uaddr1, laddr1;
   logic         valid1, complete1, dirty1, hit1, avail1;
   logic [26:0]  addr1;
   logic [0:0]   next1;

   procyon_ccu_mhq_entry_mb #(.OPTN_CCU_BEAT_SIZE(32)) u_dut1 (
      .clk(clk), .rst(rst1),
      .o_mhq_entry_valid(valid1), .o_mhq_entry_complete(complete1), .o_mhq_entry_dirty(dirty1),
      .o_mhq_entry_addr(addr1), .o_mhq_entry_data(data1), .o_ccu_next_beat(next1),
      .i_lookup_addr(laddr1), .o_lookup_hit(hit1), .o_lookup_beat_avail(avail1),
      .i_update_en(en1), .i_update_we(we1), .i_update_wr_data(wdata1),
      .i_update_byte_select(sel1), .i_update_addr(uaddr1),
      .i_ccu_beat_valid(bv1), .i_ccu_beat_data(bdata1), .i_fill_launched(launch1)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Line-level reference model: fill order is crit, crit+1, ... mod NB
   bit          m_valid, m_dirty;
   logic [26:0] m_addr;
   logic [7:0]  m_data [LINE];
   bit          m_upd  [LINE];
   bit          m_arr  [NB];
   int          m_crit, m_cnt;

   typedef struct {
      logic valid, complete, dirty, hit, avail;
      logic [26:0] addr;
      logic [255:0] data;
      logic [1:0] next;
   } exp_t;
   exp_t sbq[$];

   task automatic model_reset();
      m_valid = 0; m_dirty = 0; m_addr = '0; m_crit = 0; m_cnt = 0;
      for (int i = 0; i < LINE; i++) begin m_data[i] = 8'h00; m_upd[i] = 0; end
      for (int b = 0; b < NB; b++) m_arr[b] = 0;
   endtask

   // Push the expected view of the current cycle, advance the model, then clock.
   task automatic step();
      exp_t e;
      int nxt;
      nxt = (m_crit + m_cnt) % NB;
      for (int i = 0; i < LINE; i++) e.data[i*8 +: 8] = m_data[i];
      e.valid    = m_valid;
      e.dirty    = m_dirty;
      e.addr     = m_addr;
      e.next     = 2'(nxt);
      e.complete = m_valid && (m_cnt == NB) && !(en && we);
      e.hit      = m_valid && (laddr[31:5] == m_addr);
      e.avail    = e.hit && m_arr[laddr[4:3]];
      sbq.push_back(e);
      if (rst) model_reset();
      else if (!m_valid) begin
         if (en) begin
            m_valid = 1; m_addr = uaddr[31:5]; m_dirty = we; m_cnt = 0;
`ifdef PCYN_MHQ_CRIT_BEAT_FIRST_EN
            m_crit = int'(uaddr[4:3]);
`else
            m_crit = 0;
`endif
            for (int i = 0; i < LINE; i++) m_upd[i] = 0;
            for (int b = 0; b < NB; b++) m_arr[b] = 0;
         end
      end else begin
         if (en && we) begin
            m_dirty = 1;
            for (int i = 0; i < LINE; i++)
               if (sel[i]) begin m_data[i] = wdata[i*8 +: 8]; m_upd[i] = 1; end
         end
         if (m_cnt < NB && bv) begin
            for (int j = 0; j < BEAT; j++)
               if (!m_upd[nxt*BEAT + j]) m_data[nxt*BEAT + j] = bdata[j*8 +: 8];
            m_arr[nxt] = 1;
            m_cnt++;
         end else if (m_cnt == NB && launch && !(en && we)) m_valid = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      rst = 0; en = 0; we = 0; bv = 0; launch = 0;
      wdata = '0; sel = '0; uaddr = '0; laddr = '0; bdata = '0;
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("valid", valid, e.valid);
            chk("complete", complete, e.complete);
            chk("dirty", dirty, e.dirty);
            chk("addr", addr_o, e.addr);
            chk("data", data_o, e.data);
            chk("next_beat", next_o, e.next);
            chk("lookup_hit", hit, e.hit);
            chk("lookup_beat_avail", avail, e.avail);
         end
      end
   end

   initial begin
      idle(); rst = 1;
      rst1 = 1; en1 = 0; we1 = 0; bv1 = 0; launch1 = 0;
      wdata1 = '0; sel1 = '0; uaddr1 = '0; laddr1 = '0; bdata1 = '0;
      model_reset();
      @(posedge clk); #1;

      // single-beat instance: one beat completes the fill
      rst1 = 0; #2;
      chk("n1_reset_valid", valid1, 0); chk("n1_reset_next", next1, 0); chk("n1_reset_data", data1, 0);
      en1 = 1; uaddr1 = 32'h1010;
      @(posedge clk); #1; en1 = 0; #2;
      chk("n1_alloc_valid", valid1, 1); chk("n1_alloc_next", next1, 0); chk("n1_alloc_complete", complete1, 0);
      for (int k = 0; k < 8; k++) pay1[k*32 +: 32] = $urandom;
      bdata1 = pay1; bv1 = 1; laddr1 = 32'h1018;
      @(posedge clk); #1; bv1 = 0; #2;
      chk("n1_complete", complete1, 1); chk("n1_data", data1, pay1);
      chk("n1_hit", hit1, 1); chk("n1_avail", avail1, 1); chk("n1_next_held", next1, 0);
      launch1 = 1;
      @(posedge clk); #1; launch1 = 0; #2;
      chk("n1_launched", valid1, 0);
      @(posedge clk); #1;

      // 4-beat instance, directed scenarios
      step();                                   // reset outputs
      idle(); en = 1; uaddr = 32'h1010; step(); // allocate
      idle(); bv = 1; bdata = {8{8'hAA}}; step();
      idle(); bv = 1; bdata = {8{8'hBB}}; step();
      idle(); laddr = 32'h1018; step();
      idle(); laddr = 32'h1000; step();
      idle(); laddr = 32'h2000; step();
      idle(); bv = 1; bdata = {8{8'hCC}}; step();
      idle(); bv = 1; bdata = {8{8'hEE}}; en = 1; we = 1; sel = 32'h0000_0F00;
      wdata = {32{8'h55}}; step();              // store races final beat
      idle(); laddr = 32'h1008; step();
      idle(); en = 1; we = 1; launch = 1; sel = 32'h0000_00F0; wdata = {32{8'h77}}; step();
      idle(); launch = 1; step();
      idle(); step();
      idle(); en = 1; uaddr = 32'h1038; step();
      idle(); bv = 1; bdata = 64'h0123_4567_89AB_CDEF; step();
      idle(); bv = 1; bdata = 64'hFEDC_BA98_7654_3210; step();
      idle(); rst = 1; step();                  // reset mid-fill
      idle(); bv = 1; bdata = 64'hDEAD_BEEF_DEAD_BEEF; step();
      idle(); step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst    = ($urandom_range(99) == 0);
         en     = ($urandom_range(3) == 0);
         we     = 1'($urandom_range(1));
         for (int k = 0; k < 8; k++) wdata[k*32 +: 32] = $urandom;
         sel    = $urandom & $urandom & $urandom;
         uaddr  = 32'h1000 + ($urandom_range(3) << 5) + ($urandom & 32'h1F);
         laddr  = ($urandom_range(2) != 0) ? {m_addr, 5'($urandom)}
                                           : 32'h1000 + ($urandom_range(3) << 5) + ($urandom & 32'h1F);
         bv     = 1'($urandom_range(1));
         bdata  = {$urandom, $urandom};
         launch = ($urandom_range(2) == 0);
         step();
      end
      idle();
      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
